// File: rtl/block_pixel_reader_pkg.sv
// block_pixel_reader_pkg
// Shared constants and types for the block pixel reader.
//   BLOCK_DIM      - rows/columns of one block (8)
//   PIX_PER_BLOCK  - pixels per block (64)
//   Q_DEFAULT      - default signed sample width, taken from the `Q macro
//   pixel_t        - one {y, cb, cr} pixel at the default width
//   state_t        - reader states (IDLE / STREAM)
//   last_pixel()   - true when a {row,col} counter points at (7,7)
`ifndef Q
`define Q 12
`endif

package block_pixel_reader_pkg;

  localparam int BLOCK_DIM     = 8;
  localparam int PIX_PER_BLOCK = 64;
  localparam int Q_DEFAULT     = `Q;

  typedef struct packed {
    logic signed [Q_DEFAULT-1:0] y;
    logic signed [Q_DEFAULT-1:0] cb;
    logic signed [Q_DEFAULT-1:0] cr;
  } pixel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic logic last_pixel(input logic [5:0] idx);
    return idx == 6'(PIX_PER_BLOCK - 1);
  endfunction

endpackage

// File: rtl/block_pixel_reader_if.sv
// block_pixel_reader_if
// Bundles the block-input handshake and pixel-output handshake of the reader.
//   y_in/cb_in/cr_in  - 8x8 signed blocks, indexed [row][col]
//   in_valid/in_ready - block triplet handshake
//   y_px/cb_px/cr_px  - current pixel samples
//   px_row/px_col     - position of the current pixel in its block
//   px_last           - current pixel is (7,7)
//   out_valid/out_ready - pixel handshake
//   overflow          - sticky dropped-triplet flag
// master: the environment (producer + consumer); slave: the reader.
interface block_pixel_reader_if
  import block_pixel_reader_pkg::*;
#(
  parameter int Q = `Q
);

  logic signed [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q-1:0] y_in;
  logic signed [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q-1:0] cb_in;
  logic signed [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q-1:0] cr_in;
  logic                                              in_valid;
  logic                                              in_ready;
  logic signed [Q-1:0]                               y_px;
  logic signed [Q-1:0]                               cb_px;
  logic signed [Q-1:0]                               cr_px;
  logic [2:0]                                        px_row;
  logic [2:0]                                        px_col;
  logic                                              px_last;
  logic                                              out_valid;
  logic                                              out_ready;
  logic                                              overflow;

  modport master (
    output y_in, cb_in, cr_in, in_valid, out_ready,
    input  in_ready, y_px, cb_px, cr_px, px_row, px_col, px_last,
           out_valid, overflow
  );

  modport slave (
    input  y_in, cb_in, cr_in, in_valid, out_ready,
    output in_ready, y_px, cb_px, cr_px, px_row, px_col, px_last,
           out_valid, overflow
  );

endinterface

// File: rtl/block_pixel_reader_triplet_slot_mem.sv
// triplet_slot_mem
// Storage for DEPTH block triplets (Y, Cb, Cr), each an 8x8 block of Q-bit samples.
//   clk, rst            - clock and synchronous active-high clear of all slots
//   we, wr_idx          - write enable and slot index for a whole triplet
//   y_wr/cb_wr/cr_wr    - triplet written into slot wr_idx
//   rd_idx, rd_row/col  - slot and {row,col} of the pixel being read
//   y_rd/cb_rd/cr_rd    - combinational read of that pixel
module triplet_slot_mem
  import block_pixel_reader_pkg::*;
#(
  parameter int Q     = `Q,
  parameter int DEPTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       we,
  input  logic                                       wr_idx,
  input  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q-1:0] y_wr,
  input  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q-1:0] cb_wr,
  input  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q-1:0] cr_wr,
  input  logic                                       rd_idx,
  input  logic [2:0]                                 rd_row,
  input  logic [2:0]                                 rd_col,
  output logic [Q-1:0]                               y_rd,
  output logic [Q-1:0]                               cb_rd,
  output logic [Q-1:0]                               cr_rd
);

  typedef logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q-1:0] block_t;

  block_t y_mem  [DEPTH];
  block_t cb_mem [DEPTH];
  block_t cr_mem [DEPTH];

  // Slots are cleared on reset so the pixel outputs are never X, even
  // before the first triplet has been written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        y_mem[d]  <= '0;
        cb_mem[d] <= '0;
        cr_mem[d] <= '0;
      end
    end else if (we) begin
      y_mem[wr_idx]  <= y_wr;
      cb_mem[wr_idx] <= cb_wr;
      cr_mem[wr_idx] <= cr_wr;
    end
  end

  // Reads are combinational so a stalled {row,col} keeps the outputs stable.
  assign y_rd  = y_mem[rd_idx][rd_row][rd_col];
  assign cb_rd = cb_mem[rd_idx][rd_row][rd_col];
  assign cr_rd = cr_mem[rd_idx][rd_row][rd_col];

endmodule

// File: rtl/block_pixel_reader.sv
// block_pixel_reader
// Buffers up to DEPTH Y/Cb/Cr block triplets and streams them out one pixel
// per transfer in raster order (col fastest), with a ready/valid handshake on
// both sides and a sticky overflow flag for triplets offered while full.
//   clk  - clock, all state changes on its rising edge
//   rst  - synchronous active-high reset
//   bus  - block_pixel_reader_if.slave: block input, pixel output, overflow
module block_pixel_reader
  import block_pixel_reader_pkg::*;
#(
  parameter int Q     = `Q,
  parameter int DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  block_pixel_reader_if.slave bus
);

  state_t       state;
  state_t       next_state;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [5:0]   pix_cnt;
  logic         overflow_q;
  logic         ready_int;
  logic         valid_int;
  logic         accept;
  logic         transfer;
  logic         block_done;
  logic [Q-1:0] y_rd;
  logic [Q-1:0] cb_rd;
  logic [Q-1:0] cr_rd;

  // Handshake qualifiers; ready depends only on registered occupancy.
  assign ready_int  = int'(count) < DEPTH;
  assign valid_int  = (state == STREAM);
  assign accept     = bus.in_valid && ready_int;
  assign transfer   = valid_int && bus.out_ready;
  assign block_done = transfer && last_pixel(pix_cnt);

  // An accept and a final-pixel transfer in the same cycle cancel out.
  always_comb begin
    count_next = count;
    if (accept && !block_done) begin
      count_next = count + 2'd1;
    end else if (!accept && block_done) begin
      count_next = count - 2'd1;
    end
  end

  triplet_slot_mem #(
    .Q     (Q),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we     (accept),
    .wr_idx (wr_ptr),
    .y_wr   (bus.y_in),
    .cb_wr  (bus.cb_in),
    .cr_wr  (bus.cr_in),
    .rd_idx (rd_ptr),
    .rd_row (pix_cnt[5:3]),
    .rd_col (pix_cnt[2:0]),
    .y_rd   (y_rd),
    .cb_rd  (cb_rd),
    .cr_rd  (cr_rd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Streaming continues straight into the next slot whenever another
  // triplet is buffered or arrives on the final-pixel edge.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (accept) next_state = STREAM;
      STREAM: if (block_done && count_next == 2'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Occupancy, slot pointers, pixel counter and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      pix_cnt    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count <= count_next;
      if (accept) begin
        wr_ptr <= (DEPTH > 1) ? ~wr_ptr : 1'b0;
      end
      if (transfer) begin
        pix_cnt <= pix_cnt + 6'd1;
      end
      if (block_done) begin
        rd_ptr <= (DEPTH > 1) ? ~rd_ptr : 1'b0;
      end
      if (bus.in_valid && !ready_int) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Output decode from registered state and the combinational slot read.
  always_comb begin
    bus.in_ready  = ready_int;
    bus.out_valid = valid_int;
    bus.px_row    = pix_cnt[5:3];
    bus.px_col    = pix_cnt[2:0];
    bus.px_last   = valid_int && last_pixel(pix_cnt);
    bus.y_px      = y_rd;
    bus.cb_px     = cb_rd;
    bus.cr_px     = cr_rd;
    bus.overflow  = overflow_q;
  end

endmodule
